// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Port 0 is the execute stage and port 1 is the branch/address unit.
//   Each port has a valid/ready request channel, a one-entry registered
//   response buffer and an accepted-operation counter.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin between ports when both are eligible
//                  undefined -> fixed priority, port 0 always wins
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake for port N
//   reqN_op/a/b/imm/shamt     request opcode and operands for port N
//   rspN_valid/ready/data     registered response for port N
//   alu_control/src1/src2/imm_val_r/shamt  ALU input drives (all 0 when idle)
//   alu_result                combinational ALU output
//   cntN                      accepted-request counter for port N (wraps)
//   busy                      any response buffer full
module alu_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [5:0]       req0_op,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [31:0]      req0_imm,
   input  logic [3:0]       req0_shamt,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [5:0]       req1_op,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [31:0]      req1_imm,
   input  logic [3:0]       req1_shamt,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_data,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_data,
   output logic [31:0]      alu_src1,
   output logic [31:0]      alu_src2,
   output logic [31:0]      alu_imm_val_r,
   output logic [5:0]       alu_control,
   output logic [3:0]       alu_shamt,
   input  logic [31:0]      alu_result,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             busy
);

   logic [1:0]       full_q, full_d;
   logic [31:0]      data0_q, data0_d, data1_q, data1_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic [1:0]       ready_raw, elig, grant;
`ifdef ALU_ARB_RR_EN
   logic             ptr_q, ptr_d;  // port favoured on the next contention
`endif

   // Arbitration and request-side handshake
   always_comb begin
      ready_raw[0] = !full_q[0] || rsp0_ready;
      ready_raw[1] = !full_q[1] || rsp1_ready;
      elig[0]      = req0_valid && ready_raw[0];
      elig[1]      = req1_valid && ready_raw[1];
`ifdef ALU_ARB_RR_EN
      if (elig == 2'b11) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end else begin
         grant = elig;
      end
`else
      grant = elig[0] ? 2'b01 : elig;
`endif
      // A loser of the arbitration must see ready low so it holds its request
      req0_ready = ready_raw[0] && !(elig[0] && !grant[0]);
      req1_ready = ready_raw[1] && !(elig[1] && !grant[1]);
   end

   // ALU drive: granted port's fields, otherwise all zero (no-op)
   always_comb begin
      alu_control   = 6'd0;
      alu_src1      = 32'd0;
      alu_src2      = 32'd0;
      alu_imm_val_r = 32'd0;
      alu_shamt     = 4'd0;
      if (grant[0]) begin
         alu_control   = req0_op;
         alu_src1      = req0_a;
         alu_src2      = req0_b;
         alu_imm_val_r = req0_imm;
         alu_shamt     = req0_shamt;
      end else if (grant[1]) begin
         alu_control   = req1_op;
         alu_src1      = req1_a;
         alu_src2      = req1_b;
         alu_imm_val_r = req1_imm;
         alu_shamt     = req1_shamt;
      end
   end

   // Response slots, counters and pointer
   always_comb begin
      full_d  = full_q;
      data0_d = data0_q;
      data1_d = data1_q;
      cnt0_d  = cnt0_q;
      cnt1_d  = cnt1_q;
      if (grant[0]) begin
         full_d[0] = 1'b1;
         data0_d   = alu_result;
         cnt0_d    = cnt0_q + CNT_W'(1);
      end else if (rsp0_ready) begin
         full_d[0] = 1'b0;
      end
      if (grant[1]) begin
         full_d[1] = 1'b1;
         data1_d   = alu_result;
         cnt1_d    = cnt1_q + CNT_W'(1);
      end else if (rsp1_ready) begin
         full_d[1] = 1'b0;
      end
`ifdef ALU_ARB_RR_EN
      ptr_d = ptr_q;
      if (grant != 2'b00) begin
         ptr_d = grant[0];  // port 0 granted -> favour port 1 next
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q  <= 2'b00;
         data0_q <= 32'd0;
         data1_q <= 32'd0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
`ifdef ALU_ARB_RR_EN
         ptr_q   <= 1'b0;
`endif
      end else begin
         full_q  <= full_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
`ifdef ALU_ARB_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign rsp0_valid = full_q[0];
   assign rsp1_valid = full_q[1];
   assign rsp0_data  = data0_q;
   assign rsp1_data  = data1_q;
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;
   assign busy       = |full_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a simple ALU model drives alu_result, a behavioural
// reference (slot flags, counters, winner index) predicts every output each
// cycle, and directed scenarios pin the model with literal expectations.
module tb_alu_arbiter;
   localparam int unsigned CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]       iv, irr;
   logic [1:0][5:0]  iop;
   logic [1:0][31:0] ia, ib, iimm;
   logic [1:0][3:0]  ish;
   logic [1:0]       o_rdy, o_val;
   logic [1:0][31:0] o_data;
   logic [1:0][CNT_W-1:0] o_cnt;
   logic [31:0] alu_src1, alu_src2, alu_imm, alu_res;
   logic [5:0]  alu_ctl;
   logic [3:0]  alu_sh;
   logic        o_busy;

   alu_arbiter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(iv[0]), .req0_ready(o_rdy[0]), .req0_op(iop[0]), .req0_a(ia[0]),
      .req0_b(ib[0]), .req0_imm(iimm[0]), .req0_shamt(ish[0]),
      .req1_valid(iv[1]), .req1_ready(o_rdy[1]), .req1_op(iop[1]), .req1_a(ia[1]),
      .req1_b(ib[1]), .req1_imm(iimm[1]), .req1_shamt(ish[1]),
      .rsp0_valid(o_val[0]), .rsp0_ready(irr[0]), .rsp0_data(o_data[0]),
      .rsp1_valid(o_val[1]), .rsp1_ready(irr[1]), .rsp1_data(o_data[1]),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_imm_val_r(alu_imm),
      .alu_control(alu_ctl), .alu_shamt(alu_sh), .alu_result(alu_res),
      .cnt0(o_cnt[0]), .cnt1(o_cnt[1]), .busy(o_busy)
   );

   // Stand-in ALU: a few real ops, anything else is an arbitrary mix
   function automatic logic [31:0] alu_fn(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm,
                                          input logic [3:0] sh);
      case (op)
         6'd1:    return a + b;
         6'd2:    return a - b;
         6'd3:    return a << sh;
         6'd5:    return a ^ b;
         6'd27:   return {31'd0, a == b};
         default: return (a & b) ^ imm ^ {28'd0, sh} ^ {26'd0, op};
      endcase
   endfunction

   always_comb alu_res = alu_fn(alu_ctl, alu_src1, alu_src2, alu_imm, alu_sh);

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model state
   bit              m_full [2];
   logic [31:0]     m_data [2];
   logic [CNT_W-1:0] m_cnt [2];
   int              m_ptr;
   bit              e_rdy  [2];
   logic [1:0]      s_rdy;
   logic [5:0]      s_ctl;

   task automatic model_reset();
      for (int n = 0; n < 2; n++) begin
         m_full[n] = 0;
         m_data[n] = 32'd0;
         m_cnt[n]  = '0;
      end
      m_ptr = 0;
   endtask

   // One clock cycle: predict, compare, advance the model
   task automatic do_cycle();
      bit el [2];
      int win;
      logic [31:0] res;
      @(negedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
         el[n] = iv[n] && (!m_full[n] || irr[n]);
      end
      win = -1;
      if (el[0] && el[1]) begin
`ifdef ALU_ARB_RR_EN
         win = m_ptr;
`else
         win = 0;
`endif
      end else if (el[0]) win = 0;
      else if (el[1]) win = 1;
      for (int n = 0; n < 2; n++) begin
         e_rdy[n] = (!m_full[n] || irr[n]) && !(el[n] && win != n);
      end
      s_rdy = o_rdy;
      s_ctl = alu_ctl;
      chk("req0_ready", 64'(o_rdy[0]), 64'(e_rdy[0]));
      chk("req1_ready", 64'(o_rdy[1]), 64'(e_rdy[1]));
      chk("alu_control", 64'(alu_ctl), win < 0 ? 64'd0 : 64'(iop[win]));
      chk("alu_src1", 64'(alu_src1), win < 0 ? 64'd0 : 64'(ia[win]));
      chk("alu_src2", 64'(alu_src2), win < 0 ? 64'd0 : 64'(ib[win]));
      chk("alu_imm", 64'(alu_imm), win < 0 ? 64'd0 : 64'(iimm[win]));
      chk("alu_shamt", 64'(alu_sh), win < 0 ? 64'd0 : 64'(ish[win]));
      for (int n = 0; n < 2; n++) begin
         chk($sformatf("rsp%0d_valid", n), 64'(o_val[n]), 64'(m_full[n]));
         chk($sformatf("rsp%0d_data", n), 64'(o_data[n]), 64'(m_data[n]));
         chk($sformatf("cnt%0d", n), 64'(o_cnt[n]), 64'(m_cnt[n]));
      end
      chk("busy", 64'(o_busy), 64'(m_full[0] || m_full[1]));
      res = (win < 0) ? 32'd0 : alu_fn(iop[win], ia[win], ib[win], iimm[win], ish[win]);
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (win == n) begin
               m_full[n] = 1;
               m_data[n] = res;
               m_cnt[n]  = m_cnt[n] + 1'b1;
            end else if (irr[n]) begin
               m_full[n] = 0;
            end
         end
         if (win >= 0) m_ptr = 1 - win;
      end
      #1;
   endtask

   task automatic set_req(input int n, input logic v, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      iv[n] = v; iop[n] = op; ia[n] = a; ib[n] = b; iimm[n] = 32'd0; ish[n] = 4'd0;
   endtask

   bit held [2];

   initial begin
      rst = 1'b1;
      irr = 2'b11;
      set_req(0, 1'b0, 6'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 6'd0, 32'd0, 32'd0);
      model_reset();
      do_cycle();
      do_cycle();
      rst = 1'b0;
      // Reset state
      chk("lit_reset_val0", 64'(o_val[0]), 64'd0);
      chk("lit_reset_busy", 64'(o_busy), 64'd0);
      chk("lit_reset_rdy", 64'(o_rdy), 64'd3);
      chk("lit_reset_ctl", 64'(alu_ctl), 64'd0);

      // Single add
      set_req(0, 1'b1, 6'd1, 32'd5, 32'd7);
      do_cycle();
      chk("lit_add_val", 64'(o_val[0]), 64'd1);
      chk("lit_add_data", 64'(o_data[0]), 64'd12);
      chk("lit_add_cnt", 64'(o_cnt[0]), 64'd1);

      // Drain and accept in the same cycle
      set_req(0, 1'b1, 6'd5, 32'h0F0, 32'h0FF);
      do_cycle();
      chk("lit_drain_rdy", 64'(s_rdy[0]), 64'd1);
      chk("lit_drain_data", 64'(o_data[0]), 64'h0F);
      chk("lit_drain_val", 64'(o_val[0]), 64'd1);
      chk("lit_drain_cnt", 64'(o_cnt[0]), 64'd2);

      // Backpressure on port 0; port 1 keeps flowing
      irr[0] = 1'b0;
      set_req(0, 1'b1, 6'd1, 32'd1, 32'd1);
      for (int i = 0; i < 4; i++) begin
         set_req(1, 1'b1, 6'd1, 32'(i), 32'd100);
         do_cycle();
         chk("lit_bp_rdy0", 64'(s_rdy[0]), 64'd0);
         chk("lit_bp_rdy1", 64'(s_rdy[1]), 64'd1);
         chk("lit_bp_data0", 64'(o_data[0]), 64'h0F);
         chk("lit_bp_data1", 64'(o_data[1]), 64'(100 + i));
      end

      // Reset while both slots are full
      irr = 2'b00;
      iv  = 2'b00;
      rst = 1'b1;
      do_cycle();
      rst = 1'b0;
      chk("lit_rst_val", 64'(o_val), 64'd0);
      chk("lit_rst_data0", 64'(o_data[0]), 64'd0);
      chk("lit_rst_cnt1", 64'(o_cnt[1]), 64'd0);
      chk("lit_rst_busy", 64'(o_busy), 64'd0);
      chk("lit_rst_rdy", 64'(o_rdy), 64'd3);

      // Contention: both ports valid every cycle
      irr = 2'b11;
      set_req(0, 1'b1, 6'd2, 32'd9, 32'd4);
      set_req(1, 1'b1, 6'd27, 32'd3, 32'd3);
`ifdef ALU_ARB_RR_EN
      for (int i = 0; i < 8; i++) begin
         do_cycle();
         chk("lit_rr_grant", 64'(s_ctl), (i % 2 == 0) ? 64'd2 : 64'd27);
         chk("lit_rr_cnt0", 64'(o_cnt[0]), 64'(i / 2 + 1));
         chk("lit_rr_cnt1", 64'(o_cnt[1]), 64'((i + 1) / 2));
      end
      chk("lit_rr_data0", 64'(o_data[0]), 64'd5);
      chk("lit_rr_data1", 64'(o_data[1]), 64'd1);
`else
      for (int i = 0; i < 8; i++) do_cycle();
      chk("lit_fp_cnt0", 64'(o_cnt[0]), 64'd8);
      chk("lit_fp_cnt1", 64'(o_cnt[1]), 64'd0);
      chk("lit_fp_data0", 64'(o_data[0]), 64'd5);
      iv[0] = 1'b0;
      do_cycle();
      chk("lit_fp_grant1", 64'(s_ctl), 64'd27);
      chk("lit_fp_cnt1b", 64'(o_cnt[1]), 64'd1);
      chk("lit_fp_data1", 64'(o_data[1]), 64'd1);
`endif

      // Randomized traffic, requests held while stalled
      held[0] = 0;
      held[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (!held[n]) begin
               iv[n]   = ($urandom_range(0, 3) != 0);
               iop[n]  = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(1, 5))
                                                     : 6'($urandom);
               ia[n]   = $urandom;
               ib[n]   = ($urandom_range(0, 7) == 0) ? ia[n] : $urandom;
               iimm[n] = $urandom;
               ish[n]  = 4'($urandom);
            end
            irr[n] = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 299) == 0);
         do_cycle();
         for (int n = 0; n < 2; n++) held[n] = iv[n] && !e_rdy[n];
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
